// File: rtl/dtlb_assoc.sv
// rtl/dtlb_assoc.sv - fully-associative data TLB with round-robin replacement, flush,
// per-thread fault capture and saturating hit/miss counters
module dtlb_assoc #(
  parameter int VADDR_W   = 32,
  parameter int PADDR_W   = 20,
  parameter int PAGE_W    = 12,
  parameter int N_ENTRIES = 8,
  parameter int N_THREADS = 4,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic                          req_valid,
  input  logic                          req_mem,
  input  logic [$clog2(N_THREADS)-1:0]  req_thread,
  input  logic [VADDR_W-1:0]            vaddr,
  output logic [PADDR_W-1:0]            paddr,
  output logic                          miss,
  input  logic                          write_en,
  input  logic [VADDR_W-PAGE_W-1:0]     write_vpn,
  input  logic [PADDR_W-PAGE_W-1:0]     write_ppn,
  input  logic                          flush,
  input  logic                          cnt_clr,
  input  logic [$clog2(N_THREADS)-1:0]  fault_thread,
  output logic [VADDR_W-1:0]            fault_vaddr,
  output logic [CNT_W-1:0]              hit_count,
  output logic [CNT_W-1:0]              miss_count
);
  localparam int VPN_W = VADDR_W - PAGE_W;
  localparam int PPN_W = PADDR_W - PAGE_W;
  localparam int PTR_W = $clog2(N_ENTRIES);

  logic [N_ENTRIES-1:0] valid;
  logic [VPN_W-1:0]     vpn_q [N_ENTRIES];
  logic [PPN_W-1:0]     ppn_q [N_ENTRIES];
  logic [PTR_W-1:0]     ptr;
  logic [VADDR_W-1:0]   fault_q [N_THREADS];
  logic [CNT_W-1:0]     hit_q;
  logic [CNT_W-1:0]     miss_q;

  logic [N_ENTRIES-1:0] match;
  logic [PPN_W-1:0]     hit_ppn;
  logic                 active;
  logic                 lookup_hit;
  logic                 lookup_miss;
  logic                 upd_hit;
  logic [PTR_W-1:0]     upd_idx;
  logic                 free_any;
  logic [PTR_W-1:0]     free_idx;
  logic [PTR_W-1:0]     widx;

  // The write rule keeps VPNs unique, so an OR of masked PPNs is a valid one-hot mux.
  always_comb begin
    hit_ppn = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      match[i] = valid[i] && (vpn_q[i] == vaddr[VADDR_W-1:PAGE_W]);
      if (match[i]) hit_ppn = hit_ppn | ppn_q[i];
    end
  end

  assign active      = req_valid && req_mem;
  assign lookup_hit  = active && !mode && (|match);
  assign lookup_miss = active && !mode && !(|match);
  assign paddr       = mode ? vaddr[PADDR_W-1:0] : {hit_ppn, vaddr[PAGE_W-1:0]};
  assign miss        = lookup_miss;
  assign fault_vaddr = fault_q[fault_thread];
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

  always_comb begin
    upd_hit  = 1'b0;
    upd_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = 0; i < N_ENTRIES; i++) begin
      if (valid[i] && (vpn_q[i] == write_vpn)) begin
        upd_hit = 1'b1;
        upd_idx = PTR_W'(i);
      end
    end
    // Scan downwards so the lowest invalid index is the one left standing.
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_any = 1'b1;
        free_idx = PTR_W'(i);
      end
    end
  end

  assign widx = upd_hit ? upd_idx : (free_any ? free_idx : ptr);

  always_ff @(posedge clk) begin
    if (rst && write_en && !flush) begin
      vpn_q[widx] <= write_vpn;
      ppn_q[widx] <= write_ppn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= '0;
      ptr   <= '0;
    end else if (flush) begin
      valid <= '0;
      ptr   <= '0;
    end else if (write_en && !upd_hit) begin
      if (free_any) valid[free_idx] <= 1'b1;
      else          ptr <= ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int t = 0; t < N_THREADS; t++) fault_q[t] <= '0;
    end else if (lookup_miss) begin
      fault_q[req_thread] <= vaddr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (cnt_clr) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (lookup_hit && (hit_q != '1))   hit_q  <= hit_q + 1'b1;
      if (lookup_miss && (miss_q != '1)) miss_q <= miss_q + 1'b1;
    end
  end
endmodule
